ebiu_initiator: RTL and testbench
=================================

# ebiu_initiator

Asynchronous-memory bus initiator: the master end of the Blackfin-style async memory interface (address, bank select, read/write strobes, 16-bit data, ARDY) that our FPGA channel RAMs and memory-mapped control registers respond to. It turns single-word read/write commands from on-chip logic into correctly timed strobe sequences. It is used for FPGA-side loopback self-test of the responder blocks and for driving external async peripherals. Tristating of the data bus is done at the top level from `O_data`/`O_data_oe`/`I_data`.

## Interface
- `SETUP_CYC`, default 2, cycles with address/bank valid before the strobe (≥1).
- `STROBE_CYC`, default 3, minimum strobe-low cycles (≥1).
- `HOLD_CYC`, default 1, cycles after the strobe with address/bank still valid (≥1).
- `TIMEOUT_CYC`, default 255, maximum ARDY wait cycles after minimum strobe (ARDY build only; ≥1).

Ports:
- `I_clk` in 1: single clock; all logic on the rising edge.
- `I_rst_n` in 1: asynchronous, active-low reset.
- `I_cmd_valid` in 1: command request.
- `O_cmd_ready` out 1: high only in IDLE.
- `I_cmd_we` in 1: 1 = write, 0 = read.
- `I_cmd_addr` in 16: word address.
- `I_cmd_wdata` in 16: write data.
- `O_rsp_valid` out 1: one-cycle completion pulse.
- `O_rsp_rdata` out 16: read data; 0 for writes.
- `O_rsp_err` out 1: ARDY timeout flag, qualified by `O_rsp_valid`.
- `O_addr` out 16: bus address.
- `O_ams_n` out 1: bank select, active low.
- `O_are_n` out 1: read strobe, active low.
- `O_awe_n` out 1: write strobe, active low.
- `O_data` out 16: write data to the pad.
- `O_data_oe` out 1: pad output enable.
- `I_data` in 16: data from the pad.
- `I_ardy` in 1: responder ready, high = ready; already synchronous to `I_clk`.

## Operation
- FSM states: IDLE, SETUP, STROBE, WAIT, HOLD.
- **IDLE:** `O_cmd_ready`=1; the strobes and `O_ams_n` are high.
- **Command accept:** a command is accepted on an edge where `I_cmd_valid` and `O_cmd_ready` are both high.
  - `O_addr`, the write data and the we flag are registered.
  - `O_ams_n` goes to 0 and the FSM goes to SETUP.
- **SETUP:** lasts `SETUP_CYC` cycles.
  - For writes, `O_data_oe`=1 and `O_data`=wdata from the SETUP entry onward.
  - For reads, `O_data_oe` stays 0 for the whole transaction.
- **STROBE:** `O_are_n` (read) or `O_awe_n` (write) is 0 for `STROBE_CYC` cycles.
- **End of STROBE:**
  - Without ARDY, go to HOLD.
  - With ARDY, go to WAIT if `I_ardy`=0, else go to HOLD.
- **WAIT:** the strobe stays low until `I_ardy`=1 or `TIMEOUT_CYC` cycles elapse; then go to HOLD.
- **Leaving STROBE/WAIT:**
  - On the last strobe-low edge, `I_data` is latched into `O_rsp_rdata` (reads only).
  - The strobe returns high.
  - `O_rsp_valid` pulses for the first HOLD cycle.
  - `O_rsp_err` is 1 only on timeout, in which case `O_rsp_rdata`=16'h0000.
- **HOLD:** lasts `HOLD_CYC` cycles with address, `O_ams_n`=0 and write data held; then go to IDLE.
- **Leaving HOLD:** `O_ams_n`=1 and `O_data_oe`=0 at the IDLE entry.
- **Invariants:**
  - `O_are_n` and `O_awe_n` are never both low.
  - No strobe is ever low while `O_ams_n` is high.
- **Async reset:**
  - All strobes, `O_ams_n` and `O_cmd_ready` go to their reset values immediately, including mid-strobe.
  - `O_data_oe` goes to 0 immediately.
  - The FSM returns to IDLE.
  - The transaction is abandoned with no `O_rsp_valid`.

## Timing
- **Reset values:**
  - `O_cmd_ready`=1.
  - `O_rsp_valid`=0, `O_rsp_err`=0, `O_rsp_rdata`=0.
  - `O_addr`=0, `O_data`=0, `O_data_oe`=0.
  - `O_ams_n`=1, `O_are_n`=1, `O_awe_n`=1.
- **Edge indexing:** accept at edge 0.
  - `O_ams_n` falls at edge 0.
  - The strobe falls at edge `SETUP_CYC`.
  - The strobe rises at edge `SETUP_CYC`+`STROBE_CYC`(+wait cycles); `O_rsp_valid` is high in the cycle after that edge.
  - `O_ams_n` rises at edge `SETUP_CYC`+`STROBE_CYC`+`HOLD_CYC`(+wait cycles).
- **Transaction throughput:**
  - Busy time is S+T+H cycles (plus waits).
  - At least one IDLE cycle separates transactions, so the next accept is possible at edge S+T+H+1.
- **Command inputs:** ignored while not in IDLE; they are not queued.
- **Timeout:** the WAIT counter is 8 bits, saturating compare to `TIMEOUT_CYC`.
  - `I_ardy` rising on the same edge as the timeout counts as success (`O_rsp_err`=0).

## Configuration
- `EBIU_ARDY_EN` defined: the WAIT state, timeout counter and `O_rsp_err` generation are compiled in.
- `EBIU_ARDY_EN` not defined:
  - WAIT, the counter and `TIMEOUT_CYC` are removed.
  - `I_ardy` is ignored and strobe width is exactly `STROBE_CYC`.
  - `O_rsp_err` is tied 0.

## Test plan
- **Reset:** `I_rst_n`=0 -> all outputs at reset values.
  - Release, then 10 idle cycles -> no strobe activity.
- **Default write:** write addr 16'h0012, data 16'hBEEF.
  - `O_ams_n` low 6 cycles.
  - `O_awe_n` low exactly at cycles 2–4.
  - `O_data`=16'hBEEF with `O_data_oe`=1 from cycle 0 through HOLD.
  - `O_rsp_valid` one pulse, `O_rsp_err`=0.
- **Read then back-to-back write:** read addr 16'h0100 with the responder model driving 16'h1234.
  - `O_rsp_rdata`=16'h1234.
  - The write, presented continuously, is accepted exactly one IDLE cycle later.
- **ARDY extension (`EBIU_ARDY_EN`):** hold `I_ardy`=0 for 4 cycles beyond minimum strobe.
  - `O_are_n` low 7 cycles.
  - Data latched on the final low edge, `O_rsp_err`=0.
- **ARDY timeout (`EBIU_ARDY_EN`, `TIMEOUT_CYC`=8):** hold `I_ardy`=0 forever.
  - Strobe low 3+8 cycles.
  - `O_rsp_err`=1, `O_rsp_rdata`=16'h0000, FSM returns to IDLE.
- **Reset mid-strobe:** assert `I_rst_n`=0 during STROBE of a write.
  - `O_awe_n`, `O_ams_n` go high and `O_data_oe` goes low asynchronously.
  - No `O_rsp_valid`; the next command completes normally.

Source files
------------

// File: rtl/ebiu_initiator.sv
// ebiu_initiator: async-memory bus master that turns single-word read/write commands into timed strobes.
// Build option: define EBIU_ARDY_EN to add the ARDY wait state, 8-bit timeout counter and O_rsp_err.
module ebiu_initiator #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
`ifdef EBIU_ARDY_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_cmd_valid,
  output logic        O_cmd_ready,
  input  logic        I_cmd_we,
  input  logic [15:0] I_cmd_addr,
  input  logic [15:0] I_cmd_wdata,
  output logic        O_rsp_valid,
  output logic [15:0] O_rsp_rdata,
  output logic        O_rsp_err,
  output logic [15:0] O_addr,
  output logic        O_ams_n,
  output logic        O_are_n,
  output logic        O_awe_n,
  output logic [15:0] O_data,
  output logic        O_data_oe,
  input  logic [15:0] I_data,
  input  logic        I_ardy
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          we;
  logic          accept;
  logic          done;
  logic          timeout;
  logic          strobe_next;

`ifdef EBIU_ARDY_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;
`else
  logic unused_ardy;
  assign unused_ardy = I_ardy;
`endif

  assign accept      = I_cmd_valid && O_cmd_ready;
  assign strobe_next = (next_state == STROBE) || (next_state == WAIT);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE:   if (accept) next_state = SETUP;
      SETUP:  if (cnt == SETUP_LAST) next_state = STROBE;
      STROBE: if (cnt == STROBE_LAST) begin
`ifdef EBIU_ARDY_EN
        if (!I_ardy) begin
          next_state = WAIT;
        end else begin
          next_state = HOLD;
          done       = 1'b1;
        end
`else
        next_state = HOLD;
        done       = 1'b1;
`endif
      end
`ifdef EBIU_ARDY_EN
      // A ready on the timeout edge wins over the timeout.
      WAIT: begin
        if (I_ardy) begin
          next_state = HOLD;
          done       = 1'b1;
        end else if (wait_cnt >= TIMEOUT_LAST) begin
          next_state = HOLD;
          done       = 1'b1;
          timeout    = 1'b1;
        end
      end
`endif
      HOLD:    if (cnt == HOLD_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + 1'b1;
    end
  end

`ifdef EBIU_ARDY_EN
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wait_cnt  <= '0;
      O_rsp_err <= 1'b0;
    end else begin
      O_rsp_err <= done && timeout;
      if (state != WAIT)          wait_cnt <= '0;
      else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign O_rsp_err = 1'b0;
`endif

  // Bus pins are registered from next_state so strobes are glitch-free and reset drops them at once.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_cmd_ready <= 1'b1;
      O_rsp_valid <= 1'b0;
      O_rsp_rdata <= '0;
      O_addr      <= '0;
      O_data      <= '0;
      O_data_oe   <= 1'b0;
      O_ams_n     <= 1'b1;
      O_are_n     <= 1'b1;
      O_awe_n     <= 1'b1;
      we          <= 1'b0;
    end else begin
      O_cmd_ready <= (next_state == IDLE);
      O_ams_n     <= (next_state == IDLE);
      O_are_n     <= !(strobe_next && !we);
      O_awe_n     <= !(strobe_next && we);
      O_data_oe   <= (next_state != IDLE) && (accept ? I_cmd_we : we);
      O_rsp_valid <= done;
      if (accept) begin
        we     <= I_cmd_we;
        O_addr <= I_cmd_addr;
        O_data <= I_cmd_wdata;
      end
      if (done) O_rsp_rdata <= (we || timeout) ? 16'h0000 : I_data;
    end
  end

endmodule

// File: tb/tb_ebiu_initiator.sv
// Directed bench for ebiu_initiator (S=2, T=3, H=1); ARDY cases run when EBIU_ARDY_EN is defined (TIMEOUT_CYC=8).
module tb_ebiu_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] addr;
  logic        ams_n, are_n, awe_n;
  logic [15:0] data_out, data_in;
  logic        data_oe, ardy;

  always #5 clk = ~clk;

  ebiu_initiator #(
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)
`ifdef EBIU_ARDY_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_cmd_valid(cmd_valid), .O_cmd_ready(cmd_ready), .I_cmd_we(cmd_we),
    .I_cmd_addr(cmd_addr), .I_cmd_wdata(cmd_wdata),
    .O_rsp_valid(rsp_valid), .O_rsp_rdata(rsp_rdata), .O_rsp_err(rsp_err),
    .O_addr(addr), .O_ams_n(ams_n), .O_are_n(are_n), .O_awe_n(awe_n),
    .O_data(data_out), .O_data_oe(data_oe), .I_data(data_in), .I_ardy(ardy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle masks: bit i describes the cycle following edge i (edge 0 = accept).
  logic [31:0] m_ams, m_are, m_awe, m_oe, m_vld, m_err, m_rdy;
  logic [15:0] rd_first, rd_last;
  int          inv_bad;

  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Samples n cycles; ardy_low bit e holds I_ardy low at edge e; data_in switches to dlate after cycle dsw.
  task automatic capture(input int n, input bit b2b, input logic [31:0] ardy_low,
                         input int dsw, input logic [15:0] dlate);
    bit seen = 1'b0;
    m_ams = '0; m_are = '0; m_awe = '0; m_oe = '0; m_vld = '0; m_err = '0; m_rdy = '0;
    rd_first = '0; rd_last = '0; inv_bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_ams[i] = !ams_n;
      m_are[i] = !are_n;
      m_awe[i] = !awe_n;
      m_oe[i]  = data_oe;
      m_vld[i] = rsp_valid;
      m_err[i] = rsp_valid && rsp_err;
      m_rdy[i] = cmd_ready;
      if (rsp_valid) begin
        if (!seen) rd_first = rsp_rdata;
        rd_last = rsp_rdata;
        seen    = 1'b1;
      end
      if ((!are_n && !awe_n) || ((!are_n || !awe_n) && ams_n)) inv_bad++;
      if (i == 0) begin
        if (b2b) issue(1'b1, 16'h0055, 16'h9C3A);
        else     cmd_valid = 1'b0;
      end
      if (b2b && i == 7) cmd_valid = 1'b0;
      ardy = !ardy_low[i+1];
      if (i == dsw) data_in = dlate;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    data_in = '0; ardy = 1'b1;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("rst_addr", addr, 0);
    check("rst_data", {data_oe, data_out}, 0);
    check("rst_strobes", {ams_n, are_n, awe_n}, 3'b111);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    capture(10, 1'b0, 32'h0, -1, 16'h0);
    check("idle_bus", m_ams | m_are | m_awe | m_oe | m_vld, 0);
    check("idle_ready", m_rdy, 32'h3FF);

    // Default write
    issue(1'b1, 16'h0012, 16'hBEEF);
    capture(10, 1'b0, 32'h0, -1, 16'h0);
    check("wr_ams", m_ams, 32'h3F);
    check("wr_awe", m_awe, 32'h1C);
    check("wr_are", m_are, 0);
    check("wr_oe", m_oe, 32'h3F);
    check("wr_valid", m_vld, 32'h20);
    check("wr_err", m_err, 0);
    check("wr_ready", m_rdy, 32'h3C0);
    check("wr_rdata", rd_first, 0);
    check("wr_addr", addr, 16'h0012);
    check("wr_data", data_out, 16'hBEEF);
    check("wr_invariant", inv_bad, 0);

    // Read followed by a continuously presented write
    data_in = 16'h1234;
    issue(1'b0, 16'h0100, 16'h0000);
    capture(16, 1'b1, 32'h0, -1, 16'h0);
    check("b2b_ams", m_ams, 32'h1FBF);
    check("b2b_are", m_are, 32'h1C);
    check("b2b_awe", m_awe, 32'hE00);
    check("b2b_oe", m_oe, 32'h1F80);
    check("b2b_valid", m_vld, 32'h1020);
    check("b2b_ready", m_rdy, 32'hE040);
    check("b2b_rd_rdata", rd_first, 16'h1234);
    check("b2b_wr_rdata", rd_last, 16'h0000);
    check("b2b_addr", addr, 16'h0055);
    check("b2b_data", data_out, 16'h9C3A);
    check("b2b_invariant", inv_bad, 0);

    // Reset asserted mid-strobe of a write
    issue(1'b1, 16'h0077, 16'hA5A5);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_awe_low", {awe_n, ams_n, data_oe}, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {awe_n, ams_n, are_n}, 3'b111);
    check("mid_rst_oe_ready", {data_oe, cmd_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    capture(8, 1'b0, 32'h0, -1, 16'h0);
    check("mid_no_valid", m_vld | m_ams, 0);
    data_in = 16'h4321;
    issue(1'b0, 16'h0300, 16'h0000);
    capture(10, 1'b0, 32'h0, -1, 16'h0);
    check("after_rst_are", m_are, 32'h1C);
    check("after_rst_valid", m_vld, 32'h20);
    check("after_rst_rdata", rd_first, 16'h4321);

`ifdef EBIU_ARDY_EN
    // ARDY low at edges 5..8 stretches the read strobe to 7 cycles
    data_in = 16'h1111;
    issue(1'b0, 16'h0200, 16'h0000);
    capture(14, 1'b0, 32'h1E0, 8, 16'hCAFE);
    check("ardy_are", m_are, 32'h1FC);
    check("ardy_ams", m_ams, 32'h3FF);
    check("ardy_valid", m_vld, 32'h200);
    check("ardy_err", m_err, 0);
    check("ardy_rdata", rd_first, 16'hCAFE);
    check("ardy_ready", m_rdy, 32'h3C00);

    // ARDY never arrives: timeout after 3+8 strobe cycles
    ardy    = 1'b0;
    data_in = 16'h5A5A;
    issue(1'b0, 16'h0400, 16'h0000);
    capture(16, 1'b0, 32'hFFFF_FFFF, -1, 16'h0);
    ardy = 1'b1;
    check("tmo_are", m_are, 32'h1FFC);
    check("tmo_ams", m_ams, 32'h3FFF);
    check("tmo_valid", m_vld, 32'h2000);
    check("tmo_err", m_err, 32'h2000);
    check("tmo_rdata", rd_first, 16'h0000);
    check("tmo_ready", m_rdy, 32'hC000);
    check("tmo_invariant", inv_bad, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
